// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
//   Shared types and constants for the SDRAM command-port arbiter.
//   - arb_state_e  : arbiter FSM states (IDLE -> ISSUE -> RELEASE -> IDLE)
//   - SDRAM_ADDR_W : SDRAM word address width
//   - SDRAM_DATA_W : SDRAM data width
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage : sdram_arb_pkg

// File: rtl/sdram_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Finds the first set bit of `active`
//   at or after `rr_ptr`, wrapping modulo NUM_REQ.
//   Ports:
//     active  in  NUM_REQ  per-requester active flags
//     rr_ptr  in  ID_W     index with the highest priority this round
//     found   out 1        at least one requester is active
//     idx     out ID_W     selected requester (0 when none found)
// -----------------------------------------------------------------------------
module rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] active,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  // Scan in rotated order; the first hit latches idx and blocks later hits.
  always_comb begin
    logic [ID_W-1:0] cand;
    logic            hit;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      hit   = active[cand] & ~found;
      idx   = hit ? cand : idx;
      found = found | active[cand];
    end
  end

endmodule : rr_picker

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//   Shares one SDRAM command port between NUM_REQ audio cores with round-robin
//   grant and a single transaction in flight. The winning command is latched at
//   grant; the SDRAM completion pulse is routed back to the owner only.
//   Optional watchdog: define SDRAM_ARB_TIMEOUT_EN to abort a transaction whose
//   completion does not arrive within TIMEOUT_CYC cycles.
//   Ports:
//     i_clk, i_rst_n        clock, asynchronous active-low reset
//     req_read/req_write    per-requester command requests (held until finished)
//     req_addr/req_writedata per-requester address and write data
//     req_readdata          SDRAM read data, nonzero only in the finished cycle
//     req_finished          one-hot completion pulse to the owner
//     sdram_read/sdram_write/sdram_addr/sdram_writedata  latched command
//     sdram_readdata/sdram_finished  SDRAM response
//     grant_valid/grant_id  transaction in flight / current or last owner
//     arb_timeout           1-cycle watchdog abort pulse (0 without the macro)
// -----------------------------------------------------------------------------
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = SDRAM_ADDR_W,
  parameter int DATA_W      = SDRAM_DATA_W,
  parameter int TIMEOUT_CYC = 1024,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             req_read,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]              req_readdata,
  output logic [NUM_REQ-1:0]             req_finished,
  output logic                           sdram_read,
  output logic                           sdram_write,
  output logic [ADDR_W-1:0]              sdram_addr,
  output logic [DATA_W-1:0]              sdram_writedata,
  input  logic [DATA_W-1:0]              sdram_readdata,
  input  logic                           sdram_finished,
  output logic                           grant_valid,
  output logic [ID_W-1:0]                grant_id,
  output logic                           arb_timeout
);

  // The watchdog counter needs at least one cycle of headroom.
  if (TIMEOUT_CYC < 2) begin : g_timeout_check
    $error("sdram_arbiter: TIMEOUT_CYC must be at least 2");
  end

  arb_state_e        state_q, state_d;
  logic              sdram_read_q, sdram_read_d;
  logic              sdram_write_q, sdram_write_d;
  logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
  logic [DATA_W-1:0] sdram_writedata_q, sdram_writedata_d;
  logic              grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   rr_next_s;
  logic              pick_found_s;
  logic [ID_W-1:0]   pick_idx_s;
  logic              done_s;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              arb_timeout_q, arb_timeout_d;
  logic              expired_s;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_picker (
    .active (req_read | req_write),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found_s),
    .idx    (pick_idx_s)
  );

  assign done_s    = (state_q == ISSUE) && sdram_finished;
  assign rr_next_s = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

`ifdef SDRAM_ARB_TIMEOUT_EN
  assign expired_s = (state_q == ISSUE) && !sdram_finished &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`endif

  // Next-state and command-latch logic for the grant FSM.
  always_comb begin
    state_d           = state_q;
    sdram_read_d      = sdram_read_q;
    sdram_write_d     = sdram_write_q;
    sdram_addr_d      = sdram_addr_q;
    sdram_writedata_d = sdram_writedata_q;
    grant_valid_d     = grant_valid_q;
    grant_id_d        = grant_id_q;
    rr_ptr_d          = rr_ptr_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
    arb_timeout_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d           = ISSUE;
          grant_id_d        = pick_idx_s;
          grant_valid_d     = 1'b1;
          // Write wins when a requester raises both read and write.
          sdram_write_d     = req_write[pick_idx_s];
          sdram_read_d      = ~req_write[pick_idx_s];
          sdram_addr_d      = req_addr[pick_idx_s];
          sdram_writedata_d = req_writedata[pick_idx_s];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (done_s) begin
          state_d       = RELEASE;
          sdram_read_d  = 1'b0;
          sdram_write_d = 1'b0;
          grant_valid_d = 1'b0;
          rr_ptr_d      = rr_next_s;
`ifdef SDRAM_ARB_TIMEOUT_EN
        end else if (expired_s) begin
          state_d       = RELEASE;
          sdram_read_d  = 1'b0;
          sdram_write_d = 1'b0;
          grant_valid_d = 1'b0;
          rr_ptr_d      = rr_next_s;
          arb_timeout_d = 1'b1;
`endif
        end else begin
          state_d = ISSUE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d       = IDLE;
        sdram_read_d  = 1'b0;
        sdram_write_d = 1'b0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  // Watchdog counts cycles spent in ISSUE and restarts on every new grant.
  always_comb begin
    if ((state_q == ISSUE) && (state_d == ISSUE)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = '0;
    end
  end
`endif

  // State and registered outputs; reset drops any command immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q           <= IDLE;
      sdram_read_q      <= 1'b0;
      sdram_write_q     <= 1'b0;
      sdram_addr_q      <= '0;
      sdram_writedata_q <= '0;
      grant_valid_q     <= 1'b0;
      grant_id_q        <= '0;
      rr_ptr_q          <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      to_cnt_q          <= '0;
      arb_timeout_q     <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      sdram_read_q      <= sdram_read_d;
      sdram_write_q     <= sdram_write_d;
      sdram_addr_q      <= sdram_addr_d;
      sdram_writedata_q <= sdram_writedata_d;
      grant_valid_q     <= grant_valid_d;
      grant_id_q        <= grant_id_d;
      rr_ptr_q          <= rr_ptr_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
      to_cnt_q          <= to_cnt_d;
      arb_timeout_q     <= arb_timeout_d;
`endif
    end
  end

  // Completion routing is combinational so the owner sees it in the same cycle.
  always_comb begin
    if (done_s) begin
      req_finished = NUM_REQ'(1'b1) << grant_id_q;
      req_readdata = sdram_readdata;
    end else begin
      req_finished = '0;
      req_readdata = '0;
    end
  end

  assign sdram_read      = sdram_read_q;
  assign sdram_write     = sdram_write_q;
  assign sdram_addr      = sdram_addr_q;
  assign sdram_writedata = sdram_writedata_q;
  assign grant_valid     = grant_valid_q;
  assign grant_id        = grant_id_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
  assign arb_timeout     = arb_timeout_q;
`else
  assign arb_timeout     = 1'b0;
`endif

endmodule : sdram_arbiter

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//   Directed self-checking bench for sdram_arbiter. Inputs are driven 1 time
//   unit after the rising edge; registered outputs are checked at that point,
//   combinational completion outputs 1 time unit after the response is driven.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic             i_clk;
  logic             i_rst_n;
  logic [2:0]       req_read;
  logic [2:0]       req_write;
  logic [2:0][22:0] req_addr;
  logic [2:0][31:0] req_writedata;
  logic [31:0]      req_readdata;
  logic [2:0]       req_finished;
  logic             sdram_read;
  logic             sdram_write;
  logic [22:0]      sdram_addr;
  logic [31:0]      sdram_writedata;
  logic [31:0]      sdram_readdata;
  logic             sdram_finished;
  logic             grant_valid;
  logic [1:0]       grant_id;
  logic             arb_timeout;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(
    .NUM_REQ     (3),
    .ADDR_W      (23),
    .DATA_W      (32),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_writedata   (req_writedata),
    .req_readdata    (req_readdata),
    .req_finished    (req_finished),
    .sdram_read      (sdram_read),
    .sdram_write     (sdram_write),
    .sdram_addr      (sdram_addr),
    .sdram_writedata (sdram_writedata),
    .sdram_readdata  (sdram_readdata),
    .sdram_finished  (sdram_finished),
    .grant_valid     (grant_valid),
    .grant_id        (grant_id),
    .arb_timeout     (arb_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Bounded wait for a command to appear on the SDRAM side.
  task automatic wait_cmd(input string tag);
    int n;
    n = 0;
    while (!(sdram_read || sdram_write) && n < 8) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, sdram_read | sdram_write}, 64'd1);
  endtask

  // SDRAM completes now: check routing, then the command drop on the next edge.
  task automatic complete(input string tag, input logic [31:0] data, input logic [2:0] exp_fin);
    sdram_finished = 1'b1;
    sdram_readdata = data;
    #1;
    chk({tag, "_fin"}, {61'd0, req_finished}, {61'd0, exp_fin});
    chk({tag, "_rdata"}, {32'd0, req_readdata}, {32'd0, data});
    tick();
    sdram_finished = 1'b0;
    sdram_readdata = 32'd0;
    chk({tag, "_drop"}, {62'd0, sdram_read, sdram_write}, 64'd0);
    chk({tag, "_gv0"}, {63'd0, grant_valid}, 64'd0);
  endtask

  initial begin
    i_rst_n        = 1'b0;
    req_read       = 3'b000;
    req_write      = 3'b000;
    req_addr       = '0;
    req_writedata  = '0;
    sdram_readdata = 32'd0;
    sdram_finished = 1'b0;

    // ---- Reset state ----
    tick();
    tick();
    chk("rst_cmd", {62'd0, sdram_read, sdram_write}, 64'd0);
    chk("rst_gv", {63'd0, grant_valid}, 64'd0);
    chk("rst_gid", {62'd0, grant_id}, 64'd0);
    chk("rst_addr", {41'd0, sdram_addr}, 64'd0);
    chk("rst_fin", {61'd0, req_finished}, 64'd0);
    chk("rst_to", {63'd0, arb_timeout}, 64'd0);
    i_rst_n = 1'b1;
    tick();

    // ---- Single read by requester 1, SDRAM answers after 5 cycles ----
    req_read[1] = 1'b1;
    req_addr[1] = 23'h000123;
    tick();
    chk("rd_cmd", {62'd0, sdram_read, sdram_write}, 64'd2);
    chk("rd_addr", {41'd0, sdram_addr}, 64'h123);
    chk("rd_gv", {63'd0, grant_valid}, 64'd1);
    chk("rd_gid", {62'd0, grant_id}, 64'd1);
    chk("rd_fin_early", {61'd0, req_finished}, 64'd0);
    chk("rd_rdata_idle", {32'd0, req_readdata}, 64'd0);
    repeat (4) tick();
    chk("rd_hold", {63'd0, sdram_read}, 64'd1);
    complete("rd", 32'hDEADBEEF, 3'b010);
    req_read[1] = 1'b0;
    chk("rd_rel_fin", {61'd0, req_finished}, 64'd0);
    tick();

    // ---- Reset during ISSUE (rr_ptr is 2, so requester 0 wins by wrap) ----
    req_read[0] = 1'b1;
    req_addr[0] = 23'h000040;
    tick();
    chk("rst_issue_gid", {62'd0, grant_id}, 64'd0);
    chk("rst_issue_cmd", {63'd0, sdram_read}, 64'd1);
    sdram_finished = 1'b1;
    sdram_readdata = 32'h11112222;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_cmd", {62'd0, sdram_read, sdram_write}, 64'd0);
    chk("rst_mid_gv", {63'd0, grant_valid}, 64'd0);
    chk("rst_mid_fin", {61'd0, req_finished}, 64'd0);
    chk("rst_mid_rdata", {32'd0, req_readdata}, 64'd0);
    req_read[0]    = 1'b0;
    sdram_finished = 1'b0;
    sdram_readdata = 32'd0;
    tick();
    i_rst_n = 1'b1;
    tick();

    // ---- Contention: all three hold reads, grants rotate 0,1,2,0 ----
    req_addr[0] = 23'h000010;
    req_addr[1] = 23'h000020;
    req_addr[2] = 23'h000030;
    req_read    = 3'b111;
    begin
      logic [1:0] order [4];
      logic [2:0] onehot;
      order[0] = 2'd0;
      order[1] = 2'd1;
      order[2] = 2'd2;
      order[3] = 2'd0;
      for (int g = 0; g < 4; g++) begin
        wait_cmd("cont_wait");
        chk("cont_gid", {62'd0, grant_id}, {62'd0, order[g]});
        chk("cont_addr", {41'd0, sdram_addr}, {37'd0, order[g] + 4'd1, 4'd0});
        tick();
        tick();
        onehot = 3'b001 << order[g];
        complete("cont", 32'hA0000000 + 32'(g), onehot);
      end
    end
    req_read = 3'b000;
    tick();
    tick();
    chk("cont_idle", {63'd0, grant_valid}, 64'd0);

    // ---- Requester 1 raises read and write together: write wins (rr_ptr 1 -> 2) ----
    req_read[1]      = 1'b1;
    req_write[1]     = 1'b1;
    req_addr[1]      = 23'h000055;
    req_writedata[1] = 32'hCAFEF00D;
    tick();
    chk("both_cmd", {62'd0, sdram_read, sdram_write}, 64'd1);
    chk("both_wdata", {32'd0, sdram_writedata}, 64'hCAFEF00D);
    complete("both", 32'h0, 3'b010);
    req_read[1]  = 1'b0;
    req_write[1] = 1'b0;
    tick();

    // ---- Write by 2 vs read by 0 with rr_ptr=2, then early drop by 0 ----
    req_write[2]     = 1'b1;
    req_addr[2]      = 23'h000200;
    req_writedata[2] = 32'h00010002;
    req_read[0]      = 1'b1;
    req_addr[0]      = 23'h000300;
    wait_cmd("wr_wait");
    chk("wr_gid", {62'd0, grant_id}, 64'd2);
    chk("wr_cmd", {62'd0, sdram_read, sdram_write}, 64'd1);
    chk("wr_wdata", {32'd0, sdram_writedata}, 64'h00010002);
    chk("wr_addr", {41'd0, sdram_addr}, 64'h200);
    complete("wr", 32'h0, 3'b100);
    req_write[2] = 1'b0;
    wait_cmd("rd0_wait");
    chk("rd0_gid", {62'd0, grant_id}, 64'd0);
    chk("rd0_cmd", {62'd0, sdram_read, sdram_write}, 64'd2);
    tick();
    req_read[0] = 1'b0;
    req_addr[0] = 23'h7FFFFF;
    tick();
    tick();
    chk("drop_addr", {41'd0, sdram_addr}, 64'h300);
    chk("drop_cmd", {63'd0, sdram_read}, 64'd1);
    complete("drop", 32'h5A5A0001, 3'b001);
    tick();

    // ---- sdram_finished outside ISSUE is ignored ----
    sdram_finished = 1'b1;
    sdram_readdata = 32'h12345678;
    #1;
    chk("stray_fin", {61'd0, req_finished}, 64'd0);
    chk("stray_rdata", {32'd0, req_readdata}, 64'd0);
    tick();
    sdram_finished = 1'b0;
    sdram_readdata = 32'd0;
    chk("stray_gv", {63'd0, grant_valid}, 64'd0);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // ---- Watchdog: requester 0 gets no answer, requester 1 goes next ----
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    req_read    = 3'b011;
    req_addr[0] = 23'h000400;
    req_addr[1] = 23'h000500;
    tick();
    chk("to_gid0", {62'd0, grant_id}, 64'd0);
    repeat (15) tick();
    chk("to_hold", {63'd0, sdram_read}, 64'd1);
    chk("to_not_yet", {63'd0, arb_timeout}, 64'd0);
    tick();
    chk("to_pulse", {63'd0, arb_timeout}, 64'd1);
    chk("to_drop", {63'd0, sdram_read}, 64'd0);
    chk("to_fin", {61'd0, req_finished}, 64'd0);
    req_read[0] = 1'b0;
    tick();
    chk("to_pulse_end", {63'd0, arb_timeout}, 64'd0);
    wait_cmd("to_next_wait");
    chk("to_next_gid", {62'd0, grant_id}, 64'd1);
    complete("to_next", 32'h0BADF00D, 3'b010);
    req_read[1] = 1'b0;
    tick();
`else
    // ---- Without the watchdog a silent SDRAM keeps the command up ----
    req_read[1] = 1'b1;
    req_addr[1] = 23'h000600;
    tick();
    repeat (40) tick();
    chk("nto_hold", {63'd0, sdram_read}, 64'd1);
    chk("nto_gv", {63'd0, grant_valid}, 64'd1);
    chk("nto_flag", {63'd0, arb_timeout}, 64'd0);
    complete("nto", 32'h87654321, 3'b010);
    req_read[1] = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sdram_arbiter
